// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake, operand and result bundle for serial_subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 16
);

  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] D;
  logic             Borrow;
  logic             V;
  logic             Z;
  logic             Busy;
  logic             Done;

  // Requester side: issues operands, observes result and status.
  modport master (
    output Start, A, B,
    input  D, Borrow, V, Z, Busy, Done
  );

  // Subtractor side.
  modport slave (
    input  Start, A, B,
    output D, Borrow, V, Z, Busy, Done
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell shared with the combinational adders.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  // Sum and carry-out of three input bits.
  always_comb begin
    s = x ^ y ^ z;
    c = (x & y) | (x & z) | (y & z);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B, LSB first, one bit per clock,
// computed as A + ~B + 1 through a single full_adder cell.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic              Clk,
  input  logic              Reset_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_c;

  // The preset carry of 1 plus the inverted subtrahend bit forms the two's complement of B.
  full_adder u_full_adder (
    .x (a_q[0]),
    .y (~b_q[0]),
    .z (carry_q),
    .s (fa_s),
    .c (fa_c)
  );

  // Next-state and datapath update for each FSM state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    v_d      = v_q;
    z_d      = z_q;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d  = RUN;
          a_d      = bus.A;
          b_d      = bus.B;
          carry_d  = 1'b1;
          cnt_d    = '0;
          d_d      = '0;
          borrow_d = 1'b0;
          v_d      = 1'b0;
          z_d      = 1'b0;
        end
      end
      RUN: begin
        d_d     = {fa_s, d_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          state_d  = DONE;
          borrow_d = ~fa_c;
          // carry_q is the carry into the MSB on this edge.
          v_d      = carry_q ^ fa_c;
          z_d      = (d_d == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // FSM, datapath and registered outputs; reset clears everything, dropping any partial result.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      v_q      <= v_d;
      z_q      <= z_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.D      = d_q;
  assign bus.Borrow = borrow_q;
  assign bus.V      = v_q;
  assign bus.Z      = z_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor with a queue-based result scoreboard.
module tb_serial_subtractor;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] d;
    logic         borrow;
    logic         v;
    logic         z;
  } exp_t;

  logic Clk;
  logic Reset_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every Done pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Reset_n && bus.Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done with D=0x%0h, expected no Done", bus.D);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_D", 32'(bus.D), 32'(e.d));
        check("result_Borrow", 32'(bus.Borrow), 32'(e.borrow));
        check("result_V", 32'(bus.V), 32'(e.v));
        check("result_Z", 32'(bus.Z), 32'(e.z));
      end
    end
  end

  // Accept one operation at the next edge; leaves the bench at the negedge after E0.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  // Wait for Done with a cycle bound and check latency from the accepting edge.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.Done !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(W));
    @(negedge Clk);
    check({name, "_busy_after"}, 32'(bus.Busy), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] d, input logic br, input logic v, input logic z);
    sb_q.push_back('{d: d, borrow: br, v: v, z: z});
    issue(a, b);
    check({name, "_busy"}, 32'(bus.Busy), 32'd1);
    wait_done(name);
    check({name, "_D_hold"}, 32'(bus.D), 32'(d));
  endtask

  initial begin
    int n;
    Reset_n   = 1'b0;
    bus.Start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #12;
    check("reset_D", 32'(bus.D), 32'd0);
    check("reset_Busy", 32'(bus.Busy), 32'd0);
    check("reset_Done", 32'(bus.Done), 32'd0);
    check("reset_Z", 32'(bus.Z), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    run_op("5m3",     16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);
    run_op("0m1",     16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("ovf_neg", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);
    run_op("equal",   16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("mixed",   16'h00FF, 16'h0F00, 16'hF1FF, 1'b1, 1'b0, 1'b0);

    // Start re-pulsed with new operands mid-RUN must be ignored.
    sb_q.push_back('{d: 16'h0C00, borrow: 1'b0, v: 1'b0, z: 1'b0});
    issue(16'h1000, 16'h0400);
    repeat (4) @(negedge Clk);
    bus.Start = 1'b1;
    bus.A     = 16'h0001;
    bus.B     = 16'h0002;
    @(negedge Clk);
    bus.Start = 1'b0;
    n = 5;
    while (bus.Done !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("ignore_latency", 32'(n), 32'(W));
    repeat (3) @(negedge Clk);

    // Reset mid-RUN: outputs clear at once and no Done follows.
    issue(16'h4321, 16'h1234);
    repeat (6) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("midrst_D", 32'(bus.D), 32'd0);
    check("midrst_Busy", 32'(bus.Busy), 32'd0);
    check("midrst_Done", 32'(bus.Done), 32'd0);
    check("midrst_flags", {29'd0, bus.Borrow, bus.V, bus.Z}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (W + 4) @(negedge Clk);
    check("midrst_idle", 32'(bus.Busy), 32'd0);

    run_op("post_rst", 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge Clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
